// File: rtl/squash_pkg.sv
// rtl/squash_pkg.sv - shared types for the squash redirect buffer
package squash_pkg;

    localparam int c_seq_num_bits = 5;
    localparam int c_target_bits  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } squash_state_e;

    typedef struct packed {
        logic [c_seq_num_bits-1:0] seq_num;
        logic [c_target_bits-1:0]  target;
    } pend_entry_t;

endpackage

// File: rtl/squash_redirect_buffer_if.sv
// rtl/squash_redirect_buffer_if.sv - squash in, commit in, redirect out bundle
interface squash_redirect_buffer_if #(
    parameter int p_seq_num_bits = 5
);
    logic [p_seq_num_bits-1:0] sq_seq_num;
    logic [31:0]               sq_target;
    logic                      sq_val;
    logic [p_seq_num_bits-1:0] commit_seq_num;
    logic                      commit_val;
    logic [p_seq_num_bits-1:0] redirect_seq_num;
    logic [31:0]               redirect_target;
    logic                      redirect_val;
    logic                      redirect_rdy;

    modport master (
        input  sq_seq_num, sq_target, sq_val,
        input  commit_seq_num, commit_val,
        input  redirect_rdy,
        output redirect_seq_num, redirect_target, redirect_val
    );

    modport slave (
        output sq_seq_num, sq_target, sq_val,
        output commit_seq_num, commit_val,
        output redirect_rdy,
        input  redirect_seq_num, redirect_target, redirect_val
    );
endinterface

// File: rtl/squash_age_cmp.sv
// rtl/squash_age_cmp.sv - program-order age compare relative to the commit head
module squash_age_cmp #(
    parameter int p_seq_num_bits = 5
) (
    input  logic [p_seq_num_bits-1:0] a,
    input  logic [p_seq_num_bits-1:0] b,
    input  logic [p_seq_num_bits-1:0] head,
    output logic                      a_is_older
);
    logic [p_seq_num_bits-1:0] a_dist;
    logic [p_seq_num_bits-1:0] b_dist;

    // Distances wrap naturally in the seq width; ties are not older.
    assign a_dist     = a - head;
    assign b_dist     = b - head;
    assign a_is_older = (a_dist < b_dist);
endmodule

// File: rtl/squash_redirect_buffer.sv
// rtl/squash_redirect_buffer.sv - keeps the oldest squash and presents it as a fetch redirect; SQUASH_REDIRECT_BUFFER_BYPASS_EN adds a 0-latency IDLE path
module squash_redirect_buffer
    import squash_pkg::*;
#(
    parameter int p_seq_num_bits = c_seq_num_bits
) (
    input logic                       clk,
    input logic                       rst,
    squash_redirect_buffer_if.master  bus
);
    localparam logic [p_seq_num_bits-1:0] c_one = 1;

    squash_state_e             state;
    pend_entry_t               pend_q;
    logic                      pend_committed;
    logic [p_seq_num_bits-1:0] head;

    logic incoming_older;
    logic take_older;
    logic fire;
    logic bypass_fire;
    logic commit_hits_pend;

    squash_age_cmp #(
        .p_seq_num_bits(p_seq_num_bits)
    ) u_age_cmp (
        .a          (bus.sq_seq_num),
        .b          (pend_q.seq_num),
        .head       (head),
        .a_is_older (incoming_older)
    );

    // Once the pending entry has committed it is older than anything still in flight.
    assign take_older       = bus.sq_val && incoming_older && !pend_committed;
    assign fire             = (state == PEND) && bus.redirect_rdy;
    assign commit_hits_pend = bus.commit_val && (bus.commit_seq_num == pend_q.seq_num);

`ifdef SQUASH_REDIRECT_BUFFER_BYPASS_EN
    assign bypass_fire = (state == IDLE) && bus.sq_val && bus.redirect_rdy;

    assign bus.redirect_val     = (state == PEND) || bypass_fire;
    assign bus.redirect_seq_num = bypass_fire ? bus.sq_seq_num : pend_q.seq_num;
    assign bus.redirect_target  = bypass_fire ? bus.sq_target  : pend_q.target;
`else
    assign bypass_fire = 1'b0;

    assign bus.redirect_val     = (state == PEND);
    assign bus.redirect_seq_num = pend_q.seq_num;
    assign bus.redirect_target  = pend_q.target;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pend_q         <= '0;
            pend_committed <= 1'b0;
            head           <= '0;
        end else begin
            if (bus.commit_val) begin
                head <= bus.commit_seq_num + c_one;
            end
            unique case (state)
                IDLE: begin
                    if (bus.sq_val && !bypass_fire) begin
                        pend_q.seq_num <= bus.sq_seq_num;
                        pend_q.target  <= bus.sq_target;
                        pend_committed <= 1'b0;
                        state          <= PEND;
                    end
                end
                PEND: begin
                    // An older squash wins whether or not the current entry fires.
                    if (take_older) begin
                        pend_q.seq_num <= bus.sq_seq_num;
                        pend_q.target  <= bus.sq_target;
                        pend_committed <= 1'b0;
                    end else if (fire) begin
                        pend_committed <= 1'b0;
                        state          <= IDLE;
                    end else if (commit_hits_pend) begin
                        pend_committed <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_squash_redirect_buffer.sv
// tb/tb_squash_redirect_buffer.sv - directed bench with a transaction-level reference model
module tb_squash_redirect_buffer;
    localparam int W    = 5;
    localparam int MASK = (1 << W) - 1;
`ifdef SQUASH_REDIRECT_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    squash_redirect_buffer_if #(.p_seq_num_bits(W)) bus ();

    squash_redirect_buffer #(.p_seq_num_bits(W)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fired[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_last_fire(input string name, input int exp);
        int act;
        act = (fired.size() > 0) ? fired[$] : -1;
        check(name, act, exp);
    endtask

    // Reference model: one optional pending squash, ordered by distance from the commit head.
    bit          m_pend;
    bit          m_comm;
    int          m_seq;
    int          m_head;
    logic [31:0] m_tgt;

    function automatic bit m_older(input int a, input int b, input int h);
        return ((a - h) & MASK) < ((b - h) & MASK);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit take;
        bit fire;
        int sq;
        if (!rst_n) begin
            m_pend = 0; m_comm = 0; m_seq = 0; m_head = 0; m_tgt = '0;
        end else begin
            sq   = int'(bus.sq_seq_num);
            fire = m_pend && bus.redirect_rdy;
            if (!m_pend)
                take = bus.sq_val && !(BYP && bus.redirect_rdy);
            else
                take = bus.sq_val && !m_comm && m_older(sq, m_seq, m_head);
            if (take) begin
                m_pend = 1; m_seq = sq; m_tgt = bus.sq_target; m_comm = 0;
            end else if (fire) begin
                m_pend = 0; m_comm = 0;
            end else if (m_pend && bus.commit_val && int'(bus.commit_seq_num) == m_seq) begin
                m_comm = 1;
            end
            if (bus.commit_val) m_head = (int'(bus.commit_seq_num) + 1) & MASK;
        end
    end

    always @(negedge clk) begin
        bit exp_val;
        bit byp_now;
        byp_now = BYP && !m_pend && bus.sq_val && bus.redirect_rdy;
        exp_val = m_pend || byp_now;
        check("redirect_val", bus.redirect_val, exp_val);
        if (exp_val) begin
            check("redirect_seq_num", bus.redirect_seq_num, byp_now ? int'(bus.sq_seq_num) : m_seq);
            check("redirect_target", bus.redirect_target, byp_now ? bus.sq_target : m_tgt);
        end
        if (bus.redirect_val && bus.redirect_rdy) fired.push_back(int'(bus.redirect_seq_num));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic squash(input int s, input logic [31:0] t);
        bus.sq_val     = 1'b1;
        bus.sq_seq_num = s[W-1:0];
        bus.sq_target  = t;
        step();
        bus.sq_val     = 1'b0;
    endtask

    task automatic commit(input int s);
        bus.commit_val     = 1'b1;
        bus.commit_seq_num = s[W-1:0];
        step();
        bus.commit_val     = 1'b0;
    endtask

    task automatic fire_one();
        bus.redirect_rdy = 1'b1;
        step();
        bus.redirect_rdy = 1'b0;
    endtask

    typedef struct {
        bit sv; int seq; bit cv; int cseq; bit rdy;
    } vec_t;

    vec_t vecs[12] = '{
        '{1, 12, 0,  0, 0}, '{1, 20, 1, 11, 0}, '{1, 14, 0,  0, 0}, '{0,  0, 1, 13, 1},
        '{1, 18, 1, 14, 1}, '{1, 16, 0,  0, 0}, '{1, 15, 1, 16, 0}, '{1, 17, 0,  0, 0},
        '{0,  0, 0,  0, 1}, '{1, 25, 1, 20, 1}, '{1, 22, 0,  0, 1}, '{0,  0, 0,  0, 1}
    };

    initial begin
        bus.sq_val = 0; bus.sq_seq_num = '0; bus.sq_target = '0;
        bus.commit_val = 0; bus.commit_seq_num = '0; bus.redirect_rdy = 0;

        step(); step();
        rst_n = 1'b1;
        check("reset_val", bus.redirect_val, 0);
        check("reset_seq", bus.redirect_seq_num, 0);
        check("reset_tgt", bus.redirect_target, 0);
        check("reset_head", dut.head, 0);

        squash(3, 32'h333);
        check("pend3_val", bus.redirect_val, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_val", bus.redirect_val, 0);
        step();
        rst_n = 1'b1;
        check("post_reset_seq", bus.redirect_seq_num, 0);
        check("post_reset_tgt", bus.redirect_target, 0);
        check("post_reset_head", dut.head, 0);
        check("post_reset_committed", dut.pend_committed, 0);

        squash(4, 32'h100);
        check("single_val", bus.redirect_val, 1);
        check("single_seq", bus.redirect_seq_num, 4);
        check("single_tgt", bus.redirect_target, 32'h100);
        fire_one();
        check_last_fire("single_fired", 4);
        check("single_idle", bus.redirect_val, 0);

        commit(1);
        squash(6, 32'h600);
        squash(3, 32'h300);
        squash(9, 32'h900);
        check("replace_seq", bus.redirect_seq_num, 3);
        check("replace_tgt", bus.redirect_target, 32'h300);
        fire_one();
        check_last_fire("replace_fired", 3);

        commit(29);
        squash(1, 32'h11);
        squash(31, 32'h1f);
        check("wrap_seq", bus.redirect_seq_num, 31);
        check("wrap_tgt", bus.redirect_target, 32'h1f);
        fire_one();
        check_last_fire("wrap_fired", 31);

        squash(7, 32'h700);
        commit(7);
        check("committed_flag", dut.pend_committed, 1);
        squash(8, 32'h800);
        check("committed_seq", bus.redirect_seq_num, 7);
        fire_one();
        check_last_fire("committed_fired", 7);

        commit(4);
        squash(10, 32'ha00);
        bus.redirect_rdy = 1'b1;
        squash(9, 32'h900);
        check_last_fire("fire_capture_fired", 10);
        check("fire_capture_val", bus.redirect_val, 1);
        check("fire_capture_seq", bus.redirect_seq_num, 9);
        step();
        bus.redirect_rdy = 1'b0;
        check_last_fire("fire_capture_fired2", 9);
        check("fire_capture_idle", bus.redirect_val, 0);

`ifdef SQUASH_REDIRECT_BUFFER_BYPASS_EN
        bus.redirect_rdy = 1'b1;
        bus.sq_val = 1'b1; bus.sq_seq_num = 5'd2; bus.sq_target = 32'h22;
        #1;
        check("bypass_val", bus.redirect_val, 1);
        check("bypass_seq", bus.redirect_seq_num, 2);
        step();
        bus.sq_val = 1'b0; bus.redirect_rdy = 1'b0;
        check_last_fire("bypass_fired", 2);
        check("bypass_idle", bus.redirect_val, 0);
`endif

        foreach (vecs[i]) begin
            bus.sq_val         = vecs[i].sv;
            bus.sq_seq_num     = vecs[i].seq[W-1:0];
            bus.sq_target      = 32'h1000 + vecs[i].seq;
            bus.commit_val     = vecs[i].cv;
            bus.commit_seq_num = vecs[i].cseq[W-1:0];
            bus.redirect_rdy   = vecs[i].rdy;
            step();
        end
        bus.sq_val = 0; bus.commit_val = 0; bus.redirect_rdy = 1;
        step(); step();
        bus.redirect_rdy = 0;
        check("drain_idle", bus.redirect_val, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
